// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory load/store unit.
package dmem_pkg;

    // funct3 field (instr[14:12]) of loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone,
        StRelease
    } lsu_state_e;

    // Stores only have sb/sh/sw; loads add the unsigned byte/half forms.
    function automatic logic f3_valid(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Word-oriented req/ack memory bus driven by the load/store unit.
interface dmem_lsu_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ack;

    modport master (output req, we, addr, be, wdata, input rdata, ack);
    modport slave  (input req, we, addr, be, wdata, output rdata, ack);
endinterface

// File: rtl/lsu_lane.sv
// Byte-lane steering: store enables/replication, load extraction, alignment check.
module lsu_lane
    import dmem_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection, store replication and load extension.
    always_comb begin
        be_o         = 4'b1111;
        wdata_o      = wdata_i;
        rdata_o      = '0;
        misaligned_o = 1'b0;
        byte_sel     = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_sel     = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (funct3_i)
            F3_B, F3_BU: begin
                if (we_i) begin
                    be_o    = 4'b0001 << addr_lo_i;
                    wdata_o = {4{wdata_i[7:0]}};
                end
            end
            F3_H, F3_HU: begin
                misaligned_o = addr_lo_i[0];
                if (we_i) begin
                    be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
                    wdata_o = {2{wdata_i[15:0]}};
                end
            end
            F3_W:    misaligned_o = |addr_lo_i;
            default: ;
        endcase

        case (funct3_i)
            F3_B:    rdata_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   rdata_o = {24'b0, byte_sel};
            F3_H:    rdata_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   rdata_o = {16'b0, half_sel};
            F3_W:    rdata_o = rdata_i;
            default: rdata_o = '0;
        endcase
    end
endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: core strobes -> word-aligned req/ack transactions, done/err pulse back.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [2:0]        cpu_funct3,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_err,
    dmem_lsu_if.master        mem
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [31:0]       cpu_rdata_q, cpu_rdata_d;
    logic              cpu_err_q, cpu_err_d;

    logic              idle;
    logic              lane_we;
    logic [2:0]        lane_f3;
    logic [1:0]        lane_addr_lo;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic [31:0]       lane_rdata;
    logic              lane_misaligned;
    logic              dec_err;

    // Decode live inputs while idle; afterwards use the captured access so
    // mid-access input changes cannot disturb load extraction.
    assign idle         = (state_q == StIdle);
    assign lane_we      = idle ? cpu_write : mem_we_q;
    assign lane_f3      = idle ? cpu_funct3 : funct3_q;
    assign lane_addr_lo = idle ? cpu_addr[1:0] : addr_lo_q;

    lsu_lane u_lane (
        .we_i         (lane_we),
        .funct3_i     (lane_f3),
        .addr_lo_i    (lane_addr_lo),
        .wdata_i      (cpu_wdata),
        .rdata_i      (mem.rdata),
        .be_o         (lane_be),
        .wdata_o      (lane_wdata),
        .rdata_o      (lane_rdata),
        .misaligned_o (lane_misaligned)
    );

    assign dec_err = (cpu_read && cpu_write) || !f3_valid(cpu_write, cpu_funct3) ||
                     lane_misaligned;
    assign cnt_inc = cnt_q + 1'b1;

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        cpu_rdata_d = '0;
        cpu_err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cpu_read || cpu_write) begin
                    cnt_d = '0;
                    if (dec_err) begin
                        state_d   = StDone;
                        cpu_err_d = 1'b1;
                    end else begin
                        state_d     = StBusy;
                        mem_req_d   = 1'b1;
                        mem_we_d    = cpu_write;
                        mem_addr_d  = {cpu_addr[ADDR_W-1:2], 2'b00};
                        mem_be_d    = lane_be;
                        mem_wdata_d = lane_wdata;
                        funct3_d    = cpu_funct3;
                        addr_lo_d   = cpu_addr[1:0];
                    end
                end
            end
            StBusy: begin
                // Ack takes priority over a timeout landing on the same cycle.
                if (mem.ack) begin
                    state_d     = StDone;
                    mem_req_d   = 1'b0;
                    cpu_rdata_d = mem_we_q ? 32'b0 : lane_rdata;
                end else if (TIMEOUT_CYCLES != 0 && cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_d   = StDone;
                    mem_req_d = 1'b0;
                    cpu_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StDone:    state_d = StRelease;
            StRelease: if (!cpu_read && !cpu_write) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // State and output registers, synchronously cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            funct3_q    <= '0;
            addr_lo_q   <= '0;
            cpu_rdata_q <= '0;
            cpu_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_err_q   <= cpu_err_d;
        end
    end

    assign cpu_done  = (state_q == StDone);
    assign cpu_err   = cpu_err_q;
    assign cpu_rdata = cpu_rdata_q;
    assign mem.req   = mem_req_q;
    assign mem.we    = mem_we_q;
    assign mem.addr  = mem_addr_q;
    assign mem.be    = mem_be_q;
    assign mem.wdata = mem_wdata_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed-vector bench for dmem_lsu with a hand-driven memory side.
module tb_dmem_lsu;
    logic        clk;
    logic        rst;
    logic        cpu_read;
    logic        cpu_write;
    logic [2:0]  cpu_funct3;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_done;
    logic        cpu_err;

    int checks = 0;
    int errors = 0;

    dmem_lsu_if #(.ADDR_W(32)) mem_bus ();

    dmem_lsu #(
        .TIMEOUT_CYCLES (4),
        .ADDR_W         (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_read   (cpu_read),
        .cpu_write  (cpu_write),
        .cpu_funct3 (cpu_funct3),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_done   (cpu_done),
        .cpu_err    (cpu_err),
        .mem        (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        exp_err;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[18];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " req"}, {31'b0, mem_bus.req}, 32'h0);
        chk({tag, " we"}, {31'b0, mem_bus.we}, 32'h0);
        chk({tag, " addr"}, mem_bus.addr, 32'h0);
        chk({tag, " be"}, {28'b0, mem_bus.be}, 32'h0);
        chk({tag, " wdata"}, mem_bus.wdata, 32'h0);
        chk({tag, " done"}, {31'b0, cpu_done}, 32'h0);
        chk({tag, " err"}, {31'b0, cpu_err}, 32'h0);
        chk({tag, " rdata"}, cpu_rdata, 32'h0);
    endtask

    // One full access: strobe, optional single-cycle ack, release.
    task automatic run_vec(input vec_t v, input string tag);
        cpu_read   = v.rd;
        cpu_write  = v.wr;
        cpu_funct3 = v.f3;
        cpu_addr   = v.addr;
        cpu_wdata  = v.wdata;
        tick();
        if (v.exp_err) begin
            chk({tag, " err req"}, {31'b0, mem_bus.req}, 32'h0);
            chk({tag, " err done"}, {31'b0, cpu_done}, 32'h1);
            chk({tag, " err flag"}, {31'b0, cpu_err}, 32'h1);
            chk({tag, " err rdata"}, cpu_rdata, 32'h0);
        end else begin
            chk({tag, " req"}, {31'b0, mem_bus.req}, 32'h1);
            chk({tag, " addr"}, mem_bus.addr, v.exp_addr);
            chk({tag, " be"}, {28'b0, mem_bus.be}, {28'b0, v.exp_be});
            chk({tag, " we"}, {31'b0, mem_bus.we}, {31'b0, v.exp_we});
            if (v.wr) chk({tag, " wdata"}, mem_bus.wdata, v.exp_wdata);
            // Disturb the core side mid-access; the captured access must win.
            cpu_addr      = ~v.addr;
            cpu_funct3    = 3'b110;
            cpu_wdata     = ~v.wdata;
            mem_bus.rdata = v.rdata;
            mem_bus.ack   = 1'b1;
            tick();
            mem_bus.ack   = 1'b0;
            mem_bus.rdata = 32'h0;
            chk({tag, " done"}, {31'b0, cpu_done}, 32'h1);
            chk({tag, " err"}, {31'b0, cpu_err}, 32'h0);
            chk({tag, " rdata"}, cpu_rdata, v.exp_rdata);
            chk({tag, " req drop"}, {31'b0, mem_bus.req}, 32'h0);
        end
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        tick();
        chk({tag, " post done"}, {31'b0, cpu_done}, 32'h0);
        chk({tag, " post rdata"}, cpu_rdata, 32'h0);
        tick();
    endtask

    initial begin
        int n_req;
        int n_done;
        logic got;
        vec_t v;

        //        rd    wr    f3      addr          wdata         rdata         err   exp_addr      be       we    exp_wdata     exp_rdata
        vecs[0]  = '{1'b1, 1'b0, 3'b000, 32'h10000003, 32'h0,        32'h80AA55CC, 1'b0, 32'h10000000, 4'b1111, 1'b0, 32'h0,        32'hFFFFFF80};
        vecs[1]  = '{1'b0, 1'b1, 3'b001, 32'h10000006, 32'h1234ABCD, 32'hFFFFFFFF, 1'b0, 32'h10000004, 4'b1100, 1'b1, 32'hABCDABCD, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 3'b010, 32'h10000002, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 1'b0, 32'h0,        32'h0};
        vecs[3]  = '{1'b1, 1'b0, 3'b100, 32'h00000001, 32'h0,        32'h0000F700, 1'b0, 32'h00000000, 4'b1111, 1'b0, 32'h0,        32'h000000F7};
        vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h00000002, 32'h0,        32'h80010000, 1'b0, 32'h00000000, 4'b1111, 1'b0, 32'h0,        32'hFFFF8001};
        vecs[5]  = '{1'b1, 1'b0, 3'b101, 32'h00000000, 32'h0,        32'h1234F00D, 1'b0, 32'h00000000, 4'b1111, 1'b0, 32'h0,        32'h0000F00D};
        vecs[6]  = '{1'b1, 1'b0, 3'b010, 32'h00000008, 32'h0,        32'hDEADBEEF, 1'b0, 32'h00000008, 4'b1111, 1'b0, 32'h0,        32'hDEADBEEF};
        vecs[7]  = '{1'b0, 1'b1, 3'b000, 32'h00000005, 32'h000000A5, 32'hFFFFFFFF, 1'b0, 32'h00000004, 4'b0010, 1'b1, 32'hA5A5A5A5, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, 3'b010, 32'h0000000C, 32'hCAFEF00D, 32'hFFFFFFFF, 1'b0, 32'h0000000C, 4'b1111, 1'b1, 32'hCAFEF00D, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 3'b011, 32'h00000000, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 1'b0, 32'h0,        32'h0};
        vecs[10] = '{1'b0, 1'b1, 3'b100, 32'h00000000, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 1'b0, 32'h0,        32'h0};
        vecs[11] = '{1'b0, 1'b1, 3'b001, 32'h00000001, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 1'b0, 32'h0,        32'h0};
        vecs[12] = '{1'b1, 1'b1, 3'b010, 32'h00000000, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 1'b0, 32'h0,        32'h0};
        vecs[13] = '{1'b1, 1'b0, 3'b000, 32'h00000002, 32'h0,        32'h007F0000, 1'b0, 32'h00000000, 4'b1111, 1'b0, 32'h0,        32'h0000007F};
        vecs[14] = '{1'b0, 1'b1, 3'b000, 32'h00000003, 32'h12345678, 32'hFFFFFFFF, 1'b0, 32'h00000000, 4'b1000, 1'b1, 32'h78787878, 32'h0};
        vecs[15] = '{1'b1, 1'b0, 3'b000, 32'h00000001, 32'h0,        32'h0000F700, 1'b0, 32'h00000000, 4'b1111, 1'b0, 32'h0,        32'hFFFFFFF7};
        vecs[16] = '{1'b1, 1'b0, 3'b110, 32'h00000000, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 1'b0, 32'h0,        32'h0};
        vecs[17] = '{1'b1, 1'b0, 3'b010, 32'h00000001, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 1'b0, 32'h0,        32'h0};

        rst           = 1'b1;
        cpu_read      = 1'b0;
        cpu_write     = 1'b0;
        cpu_funct3    = 3'b000;
        cpu_addr      = 32'h0;
        cpu_wdata     = 32'h0;
        mem_bus.rdata = 32'h0;
        mem_bus.ack   = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 18; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Timeout: lhu with no ack holds req for 4 BUSY cycles, then err.
        cpu_read   = 1'b1;
        cpu_funct3 = 3'b101;
        cpu_addr   = 32'h10000002;
        tick();
        n_req = 0;
        got   = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            if (mem_bus.req) n_req++;
            if (cpu_done) begin
                got = 1'b1;
                chk("timeout err", {31'b0, cpu_err}, 32'h1);
                chk("timeout rdata", cpu_rdata, 32'h0);
                chk("timeout req drop", {31'b0, mem_bus.req}, 32'h0);
            end else begin
                tick();
            end
        end
        chk("timeout done seen", {31'b0, got}, 32'h1);
        chk("timeout req cycles", n_req, 32'd4);
        cpu_read = 1'b0;
        tick();
        tick();

        // Ack on the very cycle the counter would expire: success wins.
        cpu_read   = 1'b1;
        cpu_funct3 = 3'b010;
        cpu_addr   = 32'h00000040;
        for (int i = 0; i < 4; i++) tick();
        chk("ack@timeout req", {31'b0, mem_bus.req}, 32'h1);
        mem_bus.rdata = 32'h13579BDF;
        mem_bus.ack   = 1'b1;
        tick();
        mem_bus.ack   = 1'b0;
        chk("ack@timeout done", {31'b0, cpu_done}, 32'h1);
        chk("ack@timeout err", {31'b0, cpu_err}, 32'h0);
        chk("ack@timeout rdata", cpu_rdata, 32'h13579BDF);
        cpu_read = 1'b0;
        tick();
        tick();

        // Held strobe after done, with stray acks: no retrigger.
        cpu_read   = 1'b1;
        cpu_funct3 = 3'b010;
        cpu_addr   = 32'h00000010;
        tick();
        chk("held req", {31'b0, mem_bus.req}, 32'h1);
        mem_bus.rdata = 32'hA5A50001;
        mem_bus.ack   = 1'b1;
        tick();
        chk("held first done", {31'b0, cpu_done}, 32'h1);
        n_req  = 0;
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_bus.req) n_req++;
            if (cpu_done) n_done++;
        end
        mem_bus.ack = 1'b0;
        chk("held extra req", n_req, 32'd0);
        chk("held extra done", n_done, 32'd0);
        cpu_read = 1'b0;
        tick();
        v = vecs[6];
        run_vec(v, "after-held");

        // Reset on the 2nd BUSY cycle of an sw.
        cpu_write  = 1'b1;
        cpu_funct3 = 3'b010;
        cpu_addr   = 32'h00000020;
        cpu_wdata  = 32'h11223344;
        tick();
        chk("rst-sw req", {31'b0, mem_bus.req}, 32'h1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cpu_write = 1'b0;
        chk_all_zero("mid-rst");
        n_done = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (cpu_done) n_done++;
        end
        chk("mid-rst no done", n_done, 32'd0);
        v = vecs[3];
        run_vec(v, "post-rst lbu");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
